sprite_engine: RTL and testbench
================================

# sprite_engine

Multi-slot, pipelined sprite renderer that replaces the single hard-wired sprite pixel generator in the HDMI video path. It takes the timing generator's x/y/vde stream and composites up to N_SPRITES sprites over a background colour. Sprite positions, images and enables come from CPU-writable shadow registers that commit atomically at frame start. Sprite rows are fetched from external 1-cycle-latency block ROMs, and the block reports sprite-to-sprite collisions once per frame.

## Interface
Parameters:
- N_SPRITES, 4, number of sprite slots (1-8); lower slot index has higher draw priority.
- SPRITE_SIZE, 40, sprite edge length in pixels (square).
- IMG_W, 4, width of the image-select field; each slot may show any of 2^IMG_W images.
- ROW_W, 6, row-address width; requires 2^ROW_W ≥ SPRITE_SIZE.

Ports:
- clk, in, 1, pixel clock.
- rst, in, 1, synchronous active-high reset.
- x, in, 16, current pixel column (active-area coordinates).
- y, in, 16, current pixel row.
- vde, in, 1, video data enable.
- frame_start, in, 1, single-cycle pulse before the first active pixel of a frame.
- bg_rgb, in, 24, background colour.
- cfg_we, in, 1, shadow register write strobe.
- cfg_slot, in, 3, slot index; writes with cfg_slot ≥ N_SPRITES are ignored.
- cfg_x, in, 16, sprite left edge.
- cfg_y, in, 16, sprite top edge.
- cfg_img, in, IMG_W, image select.
- cfg_en, in, 1, slot enable.
- rom_addr, out, N_SPRITES*(IMG_W+ROW_W), per-slot address {img, row}; slot k occupies slice k.
- rom_data, in, N_SPRITES*SPRITE_SIZE*3, per-slot row data, valid one clk after rom_addr.
- R, out, 8, red component of the output pixel.
- G, out, 8, green component of the output pixel.
- B, out, 8, blue component of the output pixel.
- vde_out, out, 1, vde delayed to align with R/G/B.
- collision, out, 1, set if any two enabled sprites overlapped on opaque pixels during the previous frame.

## Operation
- Shadow registers: one {x, y, img, en} set per slot, loaded on cfg_we.
- Active registers: loaded from all shadows on frame_start.
- If cfg_we and frame_start occur in the same cycle, the new write is committed (write-through).
- Hit test, slot k: x ≥ sx && x < sx + SPRITE_SIZE && y ≥ sy && y < sy + SPRITE_SIZE && en && vde.
  - Sums are computed in 17 bits, so a sprite near 0xFFFF never wraps to column 0.
- Fetch: rom_addr slot k = {img_k, (y − sy_k)[ROW_W−1:0]}. The address is driven on every cycle, hit or not.
- Pixel select: column c = x − sx. The 3-bit index is bits [(SPRITE_SIZE−1−c)*3+2 : (SPRITE_SIZE−1−c)*3], so column 0 is the MSBs.
- Transparency: index 0 is transparent. A slot is opaque when it hit and its index is ≠ 0.
- Priority: the lowest-numbered opaque slot wins. If no slot is opaque, the output is bg_rgb.
- Palette:
  - 1 → 0000FF
  - 2 → 22B14C
  - 3 → 0A0A0A
  - 4 → FF0000
  - 5, 6, 7 → 000000
- Blanking: when the delayed vde is 0, {R,G,B} = 000000.
- Collision:
  - An internal sticky flag is set when two or more slots are opaque on the same pixel.
  - On frame_start, collision ← flag (including any collision in that same cycle), and the flag is cleared.

## Timing
- Stage 0 (registered at the end of cycle t): hit bits, column offsets, vde and bg_rgb delay. rom_addr is combinational from x, y and the active registers in cycle t.
- Stage 1 (t+1): rom_data is valid. Index select, priority, palette and collision detect run here. R/G/B/vde_out are registered at the end of t+1.
- Result: pixel (x, y) presented in cycle t appears on R/G/B at cycle t+2. Latency is exactly 2 clk.
- Reset:
  - All shadow and active registers go to 0; every slot is disabled.
  - Pipeline valid bits are cleared.
  - R, G, B, vde_out and collision are 0 the cycle after rst is sampled high.
- Reset mid-frame: output stays blank until vde propagates again (2 cycles after rst deasserts). Sprites stay disabled until configured and a frame_start occurs.
- frame_start changes active registers starting with the pixel presented in the following cycle. Pixels already in flight use the old values.

## Test plan
- Reset: hold rst 3 cycles with vde=1 → R/G/B=0, vde_out=0, collision=0. With no cfg writes, every pixel = bg_rgb, delayed 2 clk.
- Single sprite:
  - Setup: slot0 at (100,50), img 2. ROM row data has column 0 = index 1 and column 39 = index 4.
  - Expected: pixel (100,50) → 0000FF and (139,50) → FF0000, each 2 clk later. Pixel (140,50) → bg_rgb.
- Priority and transparency:
  - Setup: slots 0 and 1 both at (200,200), with slot0 column 0 = index 0 and slot1 column 0 = index 2.
  - Expected at (200,200): pixel = 22B14C and collision stays 0. Changing slot0 column 0 to index 1 gives 0000FF, and collision = 1 after the next frame_start.
- Shadow commit: write slot0 x=300 mid-frame → rendering stays at the old x until frame_start. A write coincident with frame_start takes effect for that frame.
- Edge cases:
  - Sprite at x=0xFFF0 shows no pixels at x = 0..23 (no wrap).
  - A write to cfg_slot = N_SPRITES is ignored.
  - Asserting rst mid-line blanks the output within 1 cycle.

Source files
------------

// File: rtl/sprite_engine.sv
// Multi-slot pipelined sprite compositor for the HDMI video path.
// Each slot owns shadow/active position registers and a stage-0 hit test;
// the top combines ROM row data, picks the winning slot and drives the
// palette colour two clocks after the pixel was presented.

module sprite_engine_slot #(
  parameter int SPRITE_SIZE = 40,
  parameter int IMG_W       = 4,
  parameter int ROW_W       = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [15:0]            i_x,
  input  logic [15:0]            i_y,
  input  logic                   i_vde,
  input  logic                   i_frame_start,
  input  logic                   i_we,
  input  logic [15:0]            i_cfg_x,
  input  logic [15:0]            i_cfg_y,
  input  logic [IMG_W-1:0]       i_cfg_img,
  input  logic                   i_cfg_en,
  output logic [IMG_W+ROW_W-1:0] o_rom_addr,
  output logic                   o_hit,
  output logic [ROW_W-1:0]       o_col
);
  logic [15:0]      r_sh_x, r_sh_y, r_ac_x, r_ac_y;
  logic [IMG_W-1:0] r_sh_img, r_ac_img;
  logic             r_sh_en, r_ac_en;
  logic             r_hit;
  logic [ROW_W-1:0] r_col;

  logic             w_in_x, w_in_y;
  logic [ROW_W-1:0] w_row, w_col;

  // 17-bit compares so a sprite parked near 0xFFFF cannot wrap onto column 0
  assign w_in_x = ({1'b0, i_x} >= {1'b0, r_ac_x}) &&
                  ({1'b0, i_x} <  ({1'b0, r_ac_x} + 17'(SPRITE_SIZE)));
  assign w_in_y = ({1'b0, i_y} >= {1'b0, r_ac_y}) &&
                  ({1'b0, i_y} <  ({1'b0, r_ac_y} + 17'(SPRITE_SIZE)));

  // Only the low bits of the offsets are ever needed
  assign w_row = ROW_W'(i_y) - ROW_W'(r_ac_y);
  assign w_col = ROW_W'(i_x) - ROW_W'(r_ac_x);

  assign o_rom_addr = {r_ac_img, w_row};
  assign o_hit      = r_hit;
  assign o_col      = r_col;

  // Shadow load on write; active load on frame start, with a same-cycle write passing straight through
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh_x <= '0; r_sh_y <= '0; r_sh_img <= '0; r_sh_en <= 1'b0;
      r_ac_x <= '0; r_ac_y <= '0; r_ac_img <= '0; r_ac_en <= 1'b0;
    end else begin
      if (i_we) begin
        r_sh_x <= i_cfg_x; r_sh_y <= i_cfg_y; r_sh_img <= i_cfg_img; r_sh_en <= i_cfg_en;
      end
      if (i_frame_start) begin
        r_ac_x   <= i_we ? i_cfg_x   : r_sh_x;
        r_ac_y   <= i_we ? i_cfg_y   : r_sh_y;
        r_ac_img <= i_we ? i_cfg_img : r_sh_img;
        r_ac_en  <= i_we ? i_cfg_en  : r_sh_en;
      end
    end
  end

  // Stage 0: register hit and column offset alongside the ROM fetch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hit <= 1'b0;
      r_col <= '0;
    end else begin
      r_hit <= w_in_x && w_in_y && r_ac_en && i_vde;
      r_col <= w_col;
    end
  end
endmodule

module sprite_engine #(
  parameter int N_SPRITES   = 4,
  parameter int SPRITE_SIZE = 40,
  parameter int IMG_W       = 4,
  parameter int ROW_W       = 6
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [15:0]                          i_x,
  input  logic [15:0]                          i_y,
  input  logic                                 i_vde,
  input  logic                                 i_frame_start,
  input  logic [23:0]                          i_bg_rgb,
  input  logic                                 i_cfg_we,
  input  logic [2:0]                           i_cfg_slot,
  input  logic [15:0]                          i_cfg_x,
  input  logic [15:0]                          i_cfg_y,
  input  logic [IMG_W-1:0]                     i_cfg_img,
  input  logic                                 i_cfg_en,
  output logic [N_SPRITES*(IMG_W+ROW_W)-1:0]   o_rom_addr,
  input  logic [N_SPRITES*SPRITE_SIZE*3-1:0]   i_rom_data,
  output logic [7:0]                           o_r,
  output logic [7:0]                           o_g,
  output logic [7:0]                           o_b,
  output logic                                 o_vde_out,
  output logic                                 o_collision
);
  localparam int AW = IMG_W + ROW_W;
  localparam int DW = SPRITE_SIZE * 3;

  logic [N_SPRITES-1:0]            w_hit, w_opq;
  logic [N_SPRITES-1:0][ROW_W-1:0] w_col, w_cpos;
  logic [N_SPRITES-1:0][2:0]       w_idx;
  logic [2:0]                      w_win;
  logic                            w_any;
  logic [3:0]                      w_cnt;
  logic [23:0]                     w_rgb;

  logic [1:0]  r_vld_pipe;
  logic [23:0] r_bg, r_rgb;
  logic        r_flag, r_coll;

  function automatic logic [23:0] pal(input logic [2:0] idx);
    case (idx)
      3'd1:    pal = 24'h0000FF;
      3'd2:    pal = 24'h22B14C;
      3'd3:    pal = 24'h0A0A0A;
      3'd4:    pal = 24'hFF0000;
      default: pal = 24'h000000;
    endcase
  endfunction

  for (genvar k = 0; k < N_SPRITES; k++) begin : g_slot
    sprite_engine_slot #(
      .SPRITE_SIZE(SPRITE_SIZE), .IMG_W(IMG_W), .ROW_W(ROW_W)
    ) u_slot (
      .i_clk(i_clk), .i_rst(i_rst), .i_x(i_x), .i_y(i_y), .i_vde(i_vde),
      .i_frame_start(i_frame_start),
      .i_we(i_cfg_we && (i_cfg_slot == 3'(k))),
      .i_cfg_x(i_cfg_x), .i_cfg_y(i_cfg_y), .i_cfg_img(i_cfg_img), .i_cfg_en(i_cfg_en),
      .o_rom_addr(o_rom_addr[k*AW +: AW]),
      .o_hit(w_hit[k]), .o_col(w_col[k])
    );
    // Column 0 sits in the MSBs; clamp out-of-range offsets (non-hits) to a legal slice
    assign w_cpos[k] = ({1'b0, w_col[k]} < (ROW_W+1)'(SPRITE_SIZE))
                     ? ROW_W'(SPRITE_SIZE - 1) - w_col[k] : '0;
    assign w_idx[k]  = i_rom_data[k*DW + 3*int'(w_cpos[k]) +: 3];
    assign w_opq[k]  = w_hit[k] && (w_idx[k] != 3'd0);
  end

  // Lowest opaque slot wins; count opaque slots for collision detect
  always_comb begin
    w_win = 3'd0;
    w_any = 1'b0;
    w_cnt = 4'd0;
    for (int k = N_SPRITES - 1; k >= 0; k--) begin
      if (w_opq[k]) begin
        w_win = w_idx[k];
        w_any = 1'b1;
      end
      w_cnt = w_cnt + 4'(w_opq[k]);
    end
    w_rgb = w_any ? pal(w_win) : r_bg;
  end

  // Stage 0 side-band: vde valid bit and background colour
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_pipe[0] <= 1'b0;
      r_bg          <= '0;
    end else begin
      r_vld_pipe[0] <= i_vde;
      r_bg          <= i_bg_rgb;
    end
  end

  // Stage 1: output pixel with blanking, sticky collision handed out at frame start
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_pipe[1] <= 1'b0;
      r_rgb         <= '0;
      r_flag        <= 1'b0;
      r_coll        <= 1'b0;
    end else begin
      r_vld_pipe[1] <= r_vld_pipe[0];
      r_rgb         <= r_vld_pipe[0] ? w_rgb : 24'h0;
      if (i_frame_start) begin
        r_coll <= r_flag || (w_cnt >= 4'd2);
        r_flag <= 1'b0;
      end else if (w_cnt >= 4'd2) begin
        r_flag <= 1'b1;
      end
    end
  end

  assign {o_r, o_g, o_b} = r_rgb;
  assign o_vde_out       = r_vld_pipe[1];
  assign o_collision     = r_coll;
endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine: a frame-level reference model predicts
// every output cycle, and literal expectations pin key pixels.
module tb_sprite_engine;
  localparam int N = 4, SZ = 40, IW = 4, RW = 6, AW = 10, DW = 120;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, vde, fs, we, cfg_en;
  logic [15:0] x, y, cfg_x, cfg_y;
  logic [23:0] bg;
  logic [2:0]  cfg_slot;
  logic [3:0]  cfg_img;
  logic [N*AW-1:0] rom_addr;
  logic [N*DW-1:0] rom_data;
  logic [7:0] r, g, b;
  logic vde_out, coll;

  sprite_engine #(.N_SPRITES(N), .SPRITE_SIZE(SZ), .IMG_W(IW), .ROW_W(RW)) dut (
    .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y), .i_vde(vde), .i_frame_start(fs),
    .i_bg_rgb(bg), .i_cfg_we(we), .i_cfg_slot(cfg_slot), .i_cfg_x(cfg_x),
    .i_cfg_y(cfg_y), .i_cfg_img(cfg_img), .i_cfg_en(cfg_en), .o_rom_addr(rom_addr),
    .i_rom_data(rom_data), .o_r(r), .o_g(g), .o_b(b), .o_vde_out(vde_out),
    .o_collision(coll)
  );

  // Sprite ROMs: [slot][img][row], one clock latency
  logic [DW-1:0] mem [N][16][64];
  always @(posedge clk)
    for (int k = 0; k < N; k++)
      rom_data[k*DW +: DW] <= mem[k][rom_addr[k*AW+RW +: IW]][rom_addr[k*AW +: RW]];

  function automatic logic [23:0] pal(input int i);
    case (i)
      1: return 24'h0000FF;
      2: return 24'h22B14C;
      3: return 24'h0A0A0A;
      4: return 24'hFF0000;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic int rom_idx(input int k, input int img, input int row, input int col);
    logic [DW-1:0] w;
    w = mem[k][img][row];
    return int'(w[(SZ-1-col)*3 +: 3]);
  endfunction

  function automatic logic [DW-1:0] mkrow(input int c0, input int c1, input int c39, input int rest);
    logic [DW-1:0] w;
    for (int c = 0; c < SZ; c++) w[(SZ-1-c)*3 +: 3] = 3'(rest);
    w[(SZ-1)*3 +: 3] = 3'(c0);
    w[(SZ-2)*3 +: 3] = 3'(c1);
    w[2:0]           = 3'(c39);
    return w;
  endfunction

  // Reference model: frame-level sprite state and predicted outputs
  int  sh_x[N], sh_y[N], sh_img[N], ac_x[N], ac_y[N], ac_img[N];
  bit  sh_en[N], ac_en[N];
  logic [24:0] e1, e2;
  bit mflag, mcoll, cprev;

  always @(posedge clk) begin
    logic [24:0] e;
    int nop, win, idx;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        sh_x[k] = 0; sh_y[k] = 0; sh_img[k] = 0; sh_en[k] = 0;
        ac_x[k] = 0; ac_y[k] = 0; ac_img[k] = 0; ac_en[k] = 0;
      end
      e1 = '0; e2 = '0; mflag = 0; mcoll = 0; cprev = 0;
    end else begin
      e = '0; nop = 0; win = -1;
      if (vde) begin
        for (int k = 0; k < N; k++)
          if (ac_en[k] && int'(x) >= ac_x[k] && int'(x) < ac_x[k] + SZ &&
              int'(y) >= ac_y[k] && int'(y) < ac_y[k] + SZ) begin
            idx = rom_idx(k, ac_img[k], (int'(y) - ac_y[k]) % 64, int'(x) - ac_x[k]);
            if (idx != 0) begin
              nop++;
              if (win < 0) win = idx;
            end
          end
        e = {1'b1, (win < 0) ? bg : pal(win)};
      end
      if (fs) begin mcoll = mflag | cprev; mflag = 0; end
      else mflag = mflag | cprev;
      cprev = (nop >= 2);
      e2 = e1; e1 = e;
      if (we && int'(cfg_slot) < N) begin
        sh_x[cfg_slot] = int'(cfg_x); sh_y[cfg_slot] = int'(cfg_y);
        sh_img[cfg_slot] = int'(cfg_img); sh_en[cfg_slot] = cfg_en;
      end
      if (fs)
        for (int k = 0; k < N; k++) begin
          ac_x[k] = sh_x[k]; ac_y[k] = sh_y[k]; ac_img[k] = sh_img[k]; ac_en[k] = sh_en[k];
        end
    end
  end

  int n_vec = 0, n_miss = 0;
  bit chk_on = 0;

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      n_vec++;
      if ({vde_out, r, g, b, coll} !== {e2, mcoll}) begin
        n_miss++;
        $display("FAIL cycle_cmp t=%0t got vde=%b rgb=%h coll=%b want vde=%b rgb=%h coll=%b",
                 $time, vde_out, {r, g, b}, coll, e2[24], e2[23:0], mcoll);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic cfg(input int s, input int cx, input int cy, input int im, input bit en);
    we = 1; cfg_slot = 3'(s); cfg_x = 16'(cx); cfg_y = 16'(cy); cfg_img = 4'(im); cfg_en = en;
    @(negedge clk);
    we = 0;
  endtask

  task automatic frame();
    fs = 1;
    @(negedge clk);
    fs = 0;
  endtask

  // Present one pixel, then check the result exactly two clocks later
  task automatic lit(input string nm, input int px, input int py, input logic [23:0] want);
    vde = 1; x = 16'(px); y = 16'(py);
    @(negedge clk);
    vde = 0;
    @(negedge clk);
    check(nm, {8'h0, r, g, b}, {8'h0, want});
    check({"model_", nm}, {8'h0, e2[23:0]}, {8'h0, want});
  endtask

  task automatic line(input int x0, input int x1, input int py);
    for (int i = x0; i <= x1; i++) begin
      vde = 1; x = 16'(i); y = 16'(py);
      @(negedge clk);
    end
    vde = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 16; i++)
        for (int rr = 0; rr < 64; rr++)
          for (int c = 0; c < SZ; c++)
            mem[k][i][rr][(SZ-1-c)*3 +: 3] = 3'((c + rr + i + k) % 8);

    rst = 1; vde = 1; x = 16'd10; y = 16'd10; fs = 0; we = 0; bg = 24'h123456;
    cfg_slot = 0; cfg_x = 0; cfg_y = 0; cfg_img = 0; cfg_en = 0;
    @(negedge clk);
    chk_on = 1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {6'h0, r, g, b, vde_out, coll}, 32'h0);
    rst = 0; vde = 0;
    repeat (2) @(negedge clk);
    lit("bg_only", 5, 5, 24'h123456);

    // Single sprite: slot0 at (100,50), img 2, col0=1, col39=4
    for (int rr = 0; rr < 64; rr++) mem[0][2][rr] = mkrow(1, 0, 4, 0);
    cfg(0, 100, 50, 2, 1);
    frame();
    lit("single_col0", 100, 50, 24'h0000FF);
    lit("single_col39", 139, 50, 24'hFF0000);
    lit("single_right", 140, 50, 24'h123456);
    lit("single_left", 99, 50, 24'h123456);
    lit("single_lastrow", 100, 89, 24'h0000FF);
    lit("single_below", 100, 90, 24'h123456);
    bg = 24'h00ABCD;
    lit("single_transp", 120, 60, 24'h00ABCD);

    // Priority and transparency: slots 0/1 at (200,200)
    for (int rr = 0; rr < 64; rr++) begin
      mem[0][3][rr] = mkrow(0, 3, 0, 0);
      mem[1][5][rr] = mkrow(2, 4, 0, 0);
    end
    cfg(0, 200, 200, 3, 1);
    cfg(1, 200, 200, 5, 1);
    frame();
    lit("prio_transp", 200, 200, 24'h22B14C);
    frame();
    check("coll_none", {31'h0, coll}, 32'h0);
    lit("prio_both", 201, 200, 24'h0A0A0A);
    frame();
    check("coll_set", {31'h0, coll}, 32'h1);
    frame();
    check("coll_cleared", {31'h0, coll}, 32'h0);
    for (int rr = 0; rr < 64; rr++) mem[0][3][rr] = mkrow(1, 3, 0, 0);
    lit("prio_slot0", 200, 200, 24'h0000FF);
    vde = 1; x = 16'd200; y = 16'd200;
    @(negedge clk);
    vde = 0; fs = 1;
    @(negedge clk);
    fs = 0;
    check("coll_same_cycle", {31'h0, coll}, 32'h1);
    frame();
    check("coll_after", {31'h0, coll}, 32'h0);

    // Streaming line across three overlapping slots, default patterns
    cfg(2, 215, 190, 1, 1);
    frame();
    line(195, 260, 205);
    cfg(2, 215, 190, 1, 0);
    frame();

    // Shadow commit
    cfg(0, 300, 200, 3, 1);
    cfg(1, 200, 200, 5, 0);
    lit("shadow_hold", 200, 200, 24'h0000FF);
    lit("shadow_notyet", 300, 200, 24'h00ABCD);
    frame();
    lit("shadow_moved", 300, 200, 24'h0000FF);
    lit("shadow_old", 200, 200, 24'h00ABCD);
    we = 1; cfg_slot = 0; cfg_x = 16'd400; cfg_y = 16'd200; cfg_img = 4'd3; cfg_en = 1; fs = 1;
    @(negedge clk);
    we = 0; fs = 0;
    lit("wthrough_new", 400, 200, 24'h0000FF);
    lit("wthrough_old", 300, 200, 24'h00ABCD);
    vde = 1; x = 16'd400; y = 16'd200;
    we = 1; cfg_slot = 0; cfg_x = 16'd500; fs = 1;
    @(negedge clk);
    vde = 0; we = 0; fs = 0;
    @(negedge clk);
    check("inflight_old", {8'h0, r, g, b}, 32'h0000FF);
    lit("inflight_new", 500, 200, 24'h0000FF);

    // No wrap near 0xFFFF
    for (int rr = 0; rr < 64; rr++) mem[0][6][rr] = mkrow(4, 4, 4, 4);
    cfg(0, 16'hFFF0, 200, 6, 1);
    frame();
    line(0, 23, 200);
    lit("nowrap_0", 0, 200, 24'h00ABCD);
    lit("nowrap_23", 23, 200, 24'h00ABCD);
    lit("edge_fff0", 16'hFFF0, 200, 24'hFF0000);
    lit("edge_ffff", 16'hFFFF, 200, 24'hFF0000);

    // Write to a non-existent slot
    cfg(4, 0, 0, 6, 1);
    frame();
    lit("badslot_ign", 0, 0, 24'h00ABCD);
    lit("badslot_keep", 16'hFFF0, 200, 24'hFF0000);

    // Reset mid-line
    vde = 1; y = 16'd200;
    for (int i = 0; i < 3; i++) begin
      x = 16'(16'hFFF0 + i);
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    check("midrst_blank", {7'h0, r, g, b, vde_out}, 32'h0);
    rst = 0;
    @(negedge clk);
    check("midrst_hold", {7'h0, r, g, b, vde_out}, 32'h0);
    vde = 0;
    repeat (2) @(negedge clk);
    frame();
    lit("post_rst_off", 16'hFFF0, 200, 24'h00ABCD);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
